// File: rtl/counter_pkg.sv
// Shared encodings for the parametrised up/down counter.
// Latency: none (constants and types only).
// Backpressure: not applicable.
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_ONESHOT = 2'b11
    } mode_e;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

endpackage

// File: rtl/up_down_counter_param_if.sv
// Control/status bundle of the parametrised up/down counter.
// Latency: none (wires only).
// Backpressure: none; the counter accepts a command every cycle.
interface up_down_counter_param_if #(
    parameter int WIDTH  = 4,
    parameter int STEP_W = 4
);
    logic              ena;
    logic              set;
    logic [WIDTH-1:0]  set_value;
    logic              up_down;
    logic [STEP_W-1:0] step;
    logic [1:0]        mode;
    logic [WIDTH-1:0]  count;
    logic              dir;
    logic              tc;
    logic              done;

    modport master (
        output ena, set, set_value, up_down, step, mode,
        input  count, dir, tc, done
    );

    modport slave (
        input  ena, set, set_value, up_down, step, mode,
        output count, dir, tc, done
    );
endinterface

// File: rtl/counter_next_calc.sv
// Next-count arithmetic for one enabled step: wrap, clamp or bounce at the bounds.
// Latency: purely combinational.
// Backpressure: none.
module counter_next_calc
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int STEP_W  = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 15
) (
    input  logic [WIDTH-1:0]  count,
    input  logic              dir,
    input  logic [STEP_W-1:0] step,
    input  logic [1:0]        mode,
    output logic [WIDTH-1:0]  next_count,
    output logic              hit_limit,
    output logic              flip_dir
);
    // Wide enough that count + step never overflows before the bound checks.
    localparam int CW = WIDTH + STEP_W + 1;
    localparam logic [CW-1:0] LO    = CW'(MIN_VAL);
    localparam logic [CW-1:0] HI    = CW'(MAX_VAL);
    localparam logic [CW-1:0] SPAN  = CW'(MAX_VAL - MIN_VAL);
    localparam logic [CW-1:0] RANGE = CW'(MAX_VAL - MIN_VAL + 1);

    logic [CW-1:0] cnt_x;
    logic [CW-1:0] stp_x;
    logic [CW-1:0] eff;
    logic [CW-1:0] raw_up;
    logic [CW-1:0] raw_dn;
    logic [CW-1:0] lo_plus;
    logic [CW-1:0] res;

    // Clip the step to the span, then resolve the bound crossing for the mode.
    always_comb begin
        cnt_x     = CW'(count);
        stp_x     = CW'(step);
        eff       = (stp_x > SPAN) ? SPAN : stp_x;
        raw_up    = cnt_x + eff;
        raw_dn    = cnt_x - eff;
        lo_plus   = LO + eff;
        res       = cnt_x;
        hit_limit = 1'b0;
        if (dir == DIR_UP) begin
            hit_limit = (raw_up >= HI);
            if (mode == MODE_WRAP) begin
                res = (raw_up > HI) ? raw_up - RANGE : raw_up;
            end else begin
                res = hit_limit ? HI : raw_up;
            end
        end else begin
            // Compare against LO + step so the down path never goes negative.
            hit_limit = (cnt_x <= lo_plus);
            if (mode == MODE_WRAP) begin
                res = (cnt_x < lo_plus) ? cnt_x + RANGE - eff : raw_dn;
            end else begin
                res = hit_limit ? LO : raw_dn;
            end
        end
        next_count = WIDTH'(res);
        flip_dir   = hit_limit && (mode == MODE_BOUNCE);
    end

endmodule

// File: rtl/up_down_counter_param.sv
// Parametrised up/down counter with wrap/saturate/bounce/one-shot modes, tc pulse and done flag.
// Latency: one cycle from command to count/tc/done; dir is combinational.
// Backpressure: none; every edge applies reset > set > counting.
module up_down_counter_param
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MIN_VAL = 0,
    parameter int MAX_VAL = 2**WIDTH - 1,
    parameter int STEP_W  = 4
) (
    input logic clk,
    input logic reset,
    up_down_counter_param_if.slave bus
);
    localparam logic [WIDTH-1:0] LO = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] HI = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q;
    logic             dir_q;
    logic             tc_q;
    logic             done_q;
    logic             eff_dir;
    logic             counting;
    logic [WIDTH-1:0] set_clamped;
    logic [WIDTH-1:0] next_count;
    logic             hit_limit;
    logic             flip_dir;

    // Bounce follows its own direction register; other modes obey up_down.
    always_comb begin
        eff_dir     = (bus.mode == MODE_BOUNCE) ? dir_q : bus.up_down;
        counting    = bus.ena && (bus.step != '0)
                      && !((bus.mode == MODE_ONESHOT) && done_q);
        set_clamped = bus.set_value;
        if (bus.set_value <= LO) begin
            set_clamped = LO;
        end else if (bus.set_value >= HI) begin
            set_clamped = HI;
        end
    end

    counter_next_calc #(
        .WIDTH   (WIDTH),
        .STEP_W  (STEP_W),
        .MIN_VAL (MIN_VAL),
        .MAX_VAL (MAX_VAL)
    ) u_next (
        .count      (count_q),
        .dir        (eff_dir),
        .step       (bus.step),
        .mode       (bus.mode),
        .next_count (next_count),
        .hit_limit  (hit_limit),
        .flip_dir   (flip_dir)
    );

    // State update; tc only pulses when a step actually lands on or past the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= LO;
            dir_q   <= DIR_UP;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (bus.set) begin
            count_q <= set_clamped;
            dir_q   <= bus.up_down;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else if (counting) begin
            count_q <= next_count;
            tc_q    <= hit_limit && (next_count != count_q);
            if (flip_dir) begin
                dir_q <= ~dir_q;
            end
            if (hit_limit && (bus.mode == MODE_ONESHOT)) begin
                done_q <= 1'b1;
            end
        end else begin
            tc_q <= 1'b0;
        end
    end

    assign bus.count = count_q;
    assign bus.dir   = eff_dir;
    assign bus.tc    = tc_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_up_down_counter_param.sv
// Bench for up_down_counter_param: two instances (0..15 and 2..9) driven in lockstep.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_up_down_counter_param;

    logic clk = 1'b0;
    logic rst;
    logic i_ena, i_set, i_ud;
    logic [3:0] i_sv, i_step;
    logic [1:0] i_mode;

    int total = 0;
    int bad   = 0;

    // reference state: A spans 0..15, B spans 2..9
    int a_cnt, a_dq, a_tc, a_done;
    int b_cnt, b_dq, b_tc, b_done;

    always #5 clk = ~clk;

    up_down_counter_param_if #(.WIDTH(4), .STEP_W(4)) ia ();
    up_down_counter_param_if #(.WIDTH(4), .STEP_W(4)) ib ();

    assign ia.ena = i_ena;  assign ib.ena = i_ena;
    assign ia.set = i_set;  assign ib.set = i_set;
    assign ia.set_value = i_sv;  assign ib.set_value = i_sv;
    assign ia.up_down = i_ud;  assign ib.up_down = i_ud;
    assign ia.step = i_step;  assign ib.step = i_step;
    assign ia.mode = i_mode;  assign ib.mode = i_mode;

    up_down_counter_param #(.WIDTH(4), .MIN_VAL(0), .MAX_VAL(15), .STEP_W(4)) dut_a (
        .clk(clk), .reset(rst), .bus(ia));
    up_down_counter_param #(.WIDTH(4), .MIN_VAL(2), .MAX_VAL(9), .STEP_W(4)) dut_b (
        .clk(clk), .reset(rst), .bus(ib));

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        total++;
        assert (obs === 32'(exp)) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Behavioural rules of one edge, in plain integer arithmetic.
    task automatic model(input int lo, input int hi, input int cnt, input int dq, input int done,
                         output int ncnt, output int ndq, output int ntc, output int ndone);
        int s, d, tgt, lim;
        bit hit;
        ncnt = cnt; ndq = dq; ntc = 0; ndone = done;
        if (rst) begin
            ncnt = lo; ndq = 1; ndone = 0;
        end else if (i_set) begin
            ncnt = (int'(i_sv) < lo) ? lo : ((int'(i_sv) > hi) ? hi : int'(i_sv));
            ndq = int'(i_ud); ndone = 0;
        end else if (i_ena && i_step != 0 && !(i_mode == 2'd3 && done != 0)) begin
            s   = (int'(i_step) > hi - lo) ? hi - lo : int'(i_step);
            d   = (i_mode == 2'd2) ? dq : int'(i_ud);
            tgt = (d != 0) ? cnt + s : cnt - s;
            lim = (d != 0) ? hi : lo;
            hit = (d != 0) ? (tgt >= hi) : (tgt <= lo);
            if (i_mode == 2'd0) begin
                if (tgt > hi)      ncnt = tgt - (hi - lo + 1);
                else if (tgt < lo) ncnt = tgt + (hi - lo + 1);
                else               ncnt = tgt;
            end else begin
                ncnt = hit ? lim : tgt;
            end
            if (hit && i_mode == 2'd2) ndq = (d != 0) ? 0 : 1;
            if (hit && i_mode == 2'd3) ndone = 1;
            ntc = (hit && ncnt != cnt) ? 1 : 0;
        end
    endtask

    task automatic tick();
        int c, d, t, n;
        model(0, 15, a_cnt, a_dq, a_done, c, d, t, n);
        a_cnt = c; a_dq = d; a_tc = t; a_done = n;
        model(2, 9, b_cnt, b_dq, b_done, c, d, t, n);
        b_cnt = c; b_dq = d; b_tc = t; b_done = n;
        @(posedge clk);
        #1;
        check("a_count", 32'(ia.count), a_cnt);
        check("a_tc",    32'(ia.tc),    a_tc);
        check("a_done",  32'(ia.done),  a_done);
        check("a_dir",   32'(ia.dir),   (i_mode == 2'd2) ? a_dq : int'(i_ud));
        check("b_count", 32'(ib.count), b_cnt);
        check("b_tc",    32'(ib.tc),    b_tc);
        check("b_done",  32'(ib.done),  b_done);
        check("b_dir",   32'(ib.dir),   (i_mode == 2'd2) ? b_dq : int'(i_ud));
    endtask

    task automatic drive(input logic r, input logic s, input logic [3:0] sv, input logic e,
                         input logic ud, input logic [3:0] st, input logic [1:0] md);
        rst = r; i_set = s; i_sv = sv; i_ena = e; i_ud = ud; i_step = st; i_mode = md;
    endtask

    initial begin
        int exp_b[6];
        int exp_btc[6];
        int exp_bdir[6];
        a_cnt = 0; a_dq = 1; a_tc = 0; a_done = 0;
        b_cnt = 2; b_dq = 1; b_tc = 0; b_done = 0;

        // reset state
        drive(1, 0, 0, 0, 1, 0, 2'd0);
        tick();
        check("rst_a_count", 32'(ia.count), 0);
        check("rst_b_count", 32'(ib.count), 2);
        check("rst_a_tc",    32'(ia.tc), 0);

        // load wins over ena; B clamps 10 down to 9
        drive(0, 1, 4'hA, 1, 1, 1, 2'd0);
        tick();
        check("load_a", 32'(ia.count), 10);
        check("load_b_clamp", 32'(ib.count), 9);

        // wrap up 0xB..0xF then 0x0 with tc
        drive(0, 0, 0, 1, 1, 1, 2'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("wrap_seq", 32'(ia.count), 11 + i);
        end
        tick();
        check("wrap_zero", 32'(ia.count), 0);
        check("wrap_tc",   32'(ia.tc), 1);

        // saturate down by 3 from 4: 1, 0 (tc), 0 (no tc)
        drive(0, 1, 4, 1, 0, 3, 2'd1);
        tick();
        drive(0, 0, 0, 1, 0, 3, 2'd1);
        tick();
        check("sat_1", 32'(ia.count), 1);
        tick();
        check("sat_0", 32'(ia.count), 0);
        check("sat_tc", 32'(ia.tc), 1);
        tick();
        check("sat_hold", 32'(ia.count), 0);
        check("sat_hold_tc", 32'(ia.tc), 0);

        // bounce on B: 9,7,5,3,2,4 while up_down toggles
        exp_b    = '{9, 7, 5, 3, 2, 4};
        exp_btc  = '{1, 0, 0, 0, 1, 0};
        exp_bdir = '{0, 0, 0, 0, 1, 1};
        drive(0, 1, 7, 1, 1, 2, 2'd2);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(0, 0, 0, 1, i[0], 2, 2'd2);
            tick();
            check("bounce_cnt", 32'(ib.count), exp_b[i]);
            check("bounce_tc",  32'(ib.tc), exp_btc[i]);
            check("bounce_dir", 32'(ib.dir), exp_bdir[i]);
        end

        // one-shot from 13: 14, 15 done, then frozen; set clears done
        drive(0, 1, 13, 1, 1, 1, 2'd3);
        tick();
        drive(0, 0, 0, 1, 1, 1, 2'd3);
        tick();
        check("os_14", 32'(ia.count), 14);
        tick();
        check("os_15", 32'(ia.count), 15);
        check("os_done", 32'(ia.done), 1);
        check("os_tc", 32'(ia.tc), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("os_frozen", 32'(ia.count), 15);
        end
        drive(0, 1, 0, 1, 1, 1, 2'd3);
        tick();
        check("os_clear", 32'(ia.done), 0);
        drive(0, 0, 0, 1, 1, 1, 2'd3);
        tick();
        check("os_resume", 32'(ia.count), 1);

        // reset beats set and ena
        drive(1, 1, 5, 1, 1, 1, 2'd0);
        tick();
        check("rst_prio_a", 32'(ia.count), 0);
        check("rst_prio_b", 32'(ib.count), 2);

        // step 0 holds
        drive(0, 1, 6, 1, 1, 0, 2'd0);
        tick();
        drive(0, 0, 0, 1, 1, 0, 2'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("step0_hold", 32'(ia.count), 6);
            check("step0_tc", 32'(ia.tc), 0);
        end

        // oversized step clipped to the span: B 2 -> 9 with tc
        drive(0, 1, 2, 1, 1, 15, 2'd0);
        tick();
        drive(0, 0, 0, 1, 1, 15, 2'd0);
        tick();
        check("clip_b", 32'(ib.count), 9);
        check("clip_b_tc", 32'(ib.tc), 1);

        // random traffic against the model
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 39) == 0);
            i_set  = ($urandom_range(0, 7) == 0);
            i_ena  = ($urandom_range(0, 5) != 0);
            i_ud   = 1'($urandom);
            i_sv   = 4'($urandom);
            i_step = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) i_mode = 2'($urandom);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
